// File: rtl/priority_encoder_8.sv
// priority_encoder_8: registered 8-to-3 priority encoder (i8 highest); clk, rst_n async low, i1..i8 requests, {o3,o2,o1} index, o4 valid
module priority_encoder_8 (
  input  logic clk,
  input  logic rst_n,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic i8,
  output logic o1,
  output logic o2,
  output logic o3,
  output logic o4
);
  logic [2:0] idx;
  logic       any;
  always_comb begin
    idx = i8 ? 3'd7 :
          i7 ? 3'd6 :
          i6 ? 3'd5 :
          i5 ? 3'd4 :
          i4 ? 3'd3 :
          i3 ? 3'd2 :
          i2 ? 3'd1 : 3'd0;
    any = i1 | i2 | i3 | i4 | i5 | i6 | i7 | i8;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {o4, o3, o2, o1} <= 4'b0000;
    else        {o4, o3, o2, o1} <= {any, idx};
endmodule

// File: tb/tb_priority_encoder_8.sv
module tb_priority_encoder_8;
  logic clk = 1'b0;
  logic rst_n;
  logic i1, i2, i3, i4, i5, i6, i7, i8;
  logic o1, o2, o3, o4;
  logic [3:0] out;
  logic [3:0] q[$];
  int checks = 0;
  int fails = 0;

  priority_encoder_8 dut (
    .clk(clk), .rst_n(rst_n),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7), .i8(i8),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4)
  );

  always #5 clk = ~clk;
  assign out = {o4, o3, o2, o1};

  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model(input logic [7:0] v);
    model = 4'b0000;
    for (int b = 0; b < 8; b++)
      if (v[b]) model = {1'b1, 3'(b)};
  endfunction

  task automatic drive(input logic [7:0] v);
    {i8, i7, i6, i5, i4, i3, i2, i1} = v;
  endtask

  task automatic apply(input logic [7:0] v, input logic [3:0] e);
    @(negedge clk);
    drive(v);
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) chk("scoreboard", out, q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(8'hff);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", out, 4'b0000);
    drive(8'h80);
    @(posedge clk);
    #1 chk("reset_inputs_ignored", out, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h10);
    q.push_back(4'b1100);
    for (int k = 0; k < 8; k++) apply(8'(1 << k), {1'b1, 3'(k)});
    apply(8'h00, 4'b0000);
    apply(8'h01, 4'b1000);
    apply(8'b0010_0101, 4'b1101);
    apply(8'hff, 4'b1111);
    apply(8'b0000_1010, 4'b1011);
    apply(8'b0110_0000, 4'b1110);
    apply(8'hff, 4'b1111);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("reset_async", out, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 256; c++) begin
      apply(8'(c), model(8'(c)));
      apply(8'(c), model(8'(c)));
    end
    apply(8'h00, 4'b0000);
    @(posedge clk);
    #3 i8 = 1'b1;
    #2 i8 = 1'b0;
    #1 chk("glitch_invisible", out, 4'b0000);
    apply(8'h80, 4'b1111);
    #4 chk("no_early_update", out, 4'b0000);
    apply(8'h00, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
